// File: rtl/ram_sp_responder.sv
// Single-port synchronous RAM responder with post-reset clear sweep.
// Optional per-word even parity when RAM_PARITY_EN is defined.
module ram_sp_responder #(
    parameter int               ADDR_W   = 8,
    parameter int               DATA_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              init_busy,
    output logic              acc_err,
    output logic              parity_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] CLR_LAST = (ADDR_W + 1)'(DEPTH - 1);
`ifdef RAM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W:0]   clr_ptr;
    logic [WORD_W-1:0] mem [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WORD_W-1:0] mem_wdata;
    logic [WORD_W-1:0] init_word;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic              rd_hit;

`ifdef RAM_PARITY_EN
    assign init_word = {^INIT_VAL, INIT_VAL};
    assign wr_word   = {^wr_data, wr_data};
`else
    assign init_word = INIT_VAL;
    assign wr_word   = wr_data;
`endif

    assign init_busy = (state == CLEAR);
    assign rd_hit    = (state == IDLE) && rd_en;
    assign rd_word   = mem[addr];

    // State register: reset always restarts the clear sweep
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= CLEAR;
        else         state <= state_nxt;
    end

    // Next state and memory write-port selection (sweep vs. host)
    always_comb begin
        state_nxt = state;
        mem_we    = 1'b0;
        mem_waddr = addr;
        mem_wdata = wr_word;
        unique case (state)
            CLEAR: begin
                mem_we    = !sys_rst;
                mem_waddr = clr_ptr[ADDR_W-1:0];
                mem_wdata = init_word;
                if (clr_ptr == CLR_LAST) state_nxt = IDLE;
            end
            IDLE: begin
                mem_we = !sys_rst && wr_en;
            end
            default: state_nxt = CLEAR;
        endcase
    end

    // Clear-sweep pointer; wide enough that it never wraps
    always_ff @(posedge sys_clk) begin
        if (sys_rst)              clr_ptr <= '0;
        else if (state == CLEAR)  clr_ptr <= clr_ptr + 1'b1;
    end

    // Storage array; not reset, only the sweep initialises it
    always_ff @(posedge sys_clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    // Registered read port, read-first against a same-edge write
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_hit;
            if (rd_hit) data_out <= rd_word[DATA_W-1:0];
        end
    end

    // Sticky flag for any strobe arriving while the sweep runs
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            acc_err <= 1'b0;
        else if (state == CLEAR && (wr_en || rd_en))
            acc_err <= 1'b1;
    end

`ifdef RAM_PARITY_EN
    // Parity check pulses alongside rd_valid
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            parity_err <= 1'b0;
        else
            parity_err <= rd_hit &&
                (rd_word[DATA_W] != ^rd_word[DATA_W-1:0]);
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_sp_responder.sv
// Directed self-checking bench for ram_sp_responder.
// Inputs change on falling edges; outputs sampled 1ns after rising edges.
module tb_ram_sp_responder;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] addr;
    logic [7:0] wr_data;
    logic [7:0] data_out;
    logic       rd_valid;
    logic       init_busy;
    logic       acc_err;
    logic       parity_err;

    int checks = 0;
    int errors = 0;
    int n;

    ram_sp_responder dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .addr       (addr),
        .wr_data    (wr_data),
        .data_out   (data_out),
        .rd_valid   (rd_valid),
        .init_busy  (init_busy),
        .acc_err    (acc_err),
        .parity_err (parity_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic we, input logic re,
                       input logic [7:0] a, input logic [7:0] d);
        @(negedge sys_clk);
        wr_en   = we;
        rd_en   = re;
        addr    = a;
        wr_data = d;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic sweep(output int edges);
        edges = 0;
        while (init_busy === 1'b1 && edges < 1000) begin
            cyc(1'b0, 1'b0, 8'h00, 8'h00);
            edges++;
        end
    endtask

    initial begin
        sys_rst = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr    = 8'h00;
        wr_data = 8'h00;

        // 1: reset, sweep length, read of cleared word
        cyc(0, 0, 8'h00, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);
        chk("rst_busy", init_busy, 1);
        chk("rst_dout", data_out, 0);
        chk("rst_rdv", rd_valid, 0);
        chk("rst_acc", acc_err, 0);
        chk("rst_par", parity_err, 0);
        sys_rst = 1'b0;
        sweep(n);
        chk("sweep1_len", n, 256);
        cyc(0, 1, 8'h37, 8'h00);
        chk("rd37_valid", rd_valid, 1);
        chk("rd37_data", data_out, 8'h00);
        cyc(0, 0, 8'h00, 8'h00);
        chk("rd37_pulse", rd_valid, 0);
        chk("rd37_hold", data_out, 8'h00);

        // 2: full write then full back-to-back read
        for (int i = 0; i < 256; i++) begin
            cyc(1, 0, 8'(i), 8'(i));
            chk("wr_no_rdv", rd_valid, 0);
        end
        for (int i = 0; i < 256; i++) begin
            cyc(0, 1, 8'(i), 8'h00);
            chk("seq_rdv", rd_valid, 1);
            chk("seq_data", data_out, i);
            chk("seq_par", parity_err, 0);
        end
        cyc(0, 0, 8'h00, 8'h00);
        chk("seq_end_rdv", rd_valid, 0);
        chk("seq_end_hold", data_out, 8'hFF);

        // 3: simultaneous write/read is read-first
        cyc(1, 1, 8'h10, 8'hA5);
        chk("rf_old", data_out, 8'h10);
        chk("rf_rdv", rd_valid, 1);
        cyc(0, 1, 8'h10, 8'h00);
        chk("rf_new", data_out, 8'hA5);

        // 4: accesses during the sweep are ignored and flagged
        sys_rst = 1'b1;
        cyc(0, 0, 8'h00, 8'h00);
        chk("rst2_acc", acc_err, 0);
        sys_rst = 1'b0;
        cyc(1, 1, 8'h05, 8'hFF);
        chk("busy_rdv", rd_valid, 0);
        chk("busy_acc", acc_err, 1);
        chk("busy_flag", init_busy, 1);
        cyc(0, 0, 8'h00, 8'h00);
        chk("acc_sticky", acc_err, 1);
        sweep(n);
        chk("sweep2_len", n, 254);
        cyc(0, 1, 8'h05, 8'h00);
        chk("rd05_clr", data_out, 8'h00);
        chk("rd05_rdv", rd_valid, 1);
        chk("acc_kept", acc_err, 1);

        // 5: reset in the middle of a read sweep
        cyc(1, 0, 8'h05, 8'h05);
        cyc(1, 0, 8'h80, 8'h80);
        cyc(0, 1, 8'h05, 8'h00);
        chk("pre_rd05", data_out, 8'h05);
        for (int i = 8'h70; i < 8'h80; i++)
            cyc(0, 1, 8'(i), 8'h00);
        chk("pre_rd7f", data_out, 8'h00);
        sys_rst = 1'b1;
        cyc(0, 1, 8'h80, 8'h00);
        chk("mid_rst_dout", data_out, 8'h00);
        chk("mid_rst_rdv", rd_valid, 0);
        chk("mid_rst_busy", init_busy, 1);
        chk("mid_rst_acc", acc_err, 0);
        sys_rst = 1'b0;
        sweep(n);
        chk("sweep3_len", n, 256);
        cyc(0, 1, 8'h05, 8'h00);
        chk("rd05_after", data_out, 8'h00);
        cyc(0, 1, 8'h80, 8'h00);
        chk("rd80_after", data_out, 8'h00);

        // 6: parity behaviour
        cyc(1, 0, 8'h20, 8'h3C);
        cyc(1, 0, 8'h21, 8'h55);
`ifdef RAM_PARITY_EN
        dut.mem[8'h20][0] = ~dut.mem[8'h20][0];
        cyc(0, 1, 8'h20, 8'h00);
        chk("par_bad_rdv", rd_valid, 1);
        chk("par_bad", parity_err, 1);
        cyc(0, 1, 8'h21, 8'h00);
        chk("par_ok", parity_err, 0);
        chk("par_ok_data", data_out, 8'h55);
        cyc(0, 0, 8'h00, 8'h00);
        chk("par_pulse", parity_err, 0);
`else
        cyc(0, 1, 8'h20, 8'h00);
        chk("nopar_data", data_out, 8'h3C);
        chk("nopar_err", parity_err, 0);
        cyc(0, 1, 8'h21, 8'h00);
        chk("nopar_data2", data_out, 8'h55);
        chk("nopar_err2", parity_err, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
